// File: rtl/arcade_input_mapper.sv
`default_nettype none
// ============================================================================
// Module  : arcade_input_mapper
// Purpose : Synchronises arcade joystick/button inputs, cleans directions
//           (4/8-way), shapes merged coin pulses on frame ticks.
//           Optional autofire: define ARCADE_INPUT_AUTOFIRE_EN.
// Rev     : 1.0  initial release
// ============================================================================
module arcade_input_mapper #(
  parameter int NPLAYERS      = 2,
  parameter int COIN_PULSE    = 4,
  parameter int COIN_GAP      = 2,
  parameter int AUTOFIRE_RATE = 3
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    vblank,
  input  logic [7*NPLAYERS-1:0]   joy_in,
  input  logic [NPLAYERS-1:0]     mode_8way,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  input  logic [NPLAYERS-1:0]     autofire_en,
`endif
  output logic [4*NPLAYERS-1:0]   dir_out,
  output logic [3*NPLAYERS-1:0]   dir_code,
  output logic [NPLAYERS-1:0]     dir_valid,
  output logic [NPLAYERS-1:0]     fire_out,
  output logic [NPLAYERS-1:0]     start_out,
  output logic                    coin_out,
  output logic [7:0]              coin_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [7:0] PULSE_LAST = 8'(COIN_PULSE - 1);
  localparam logic [7:0] GAP_LAST   = 8'(COIN_GAP - 1);

  logic [7*NPLAYERS-1:0] joy_meta, joy_sync;
  logic                  vb_meta, vb_sync, vb_last;
  logic                  frame_tick;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      joy_meta <= '0;
      joy_sync <= '0;
      vb_meta  <= 1'b0;
      vb_sync  <= 1'b0;
      vb_last  <= 1'b0;
    end else begin
      joy_meta <= joy_in;
      joy_sync <= joy_meta;
      vb_meta  <= vblank;
      vb_sync  <= vb_meta;
      vb_last  <= vb_sync;
    end
  end

  assign frame_tick = vb_sync & ~vb_last;

  logic [NPLAYERS-1:0] coin_sync;

  for (genvar p = 0; p < NPLAYERS; p++) begin : g_player
    logic       rgt, lft, dwn, up, vert, horz;
    logic       last_horz;
    logic [3:0] clean;
    logic [2:0] code;
    logic       fire_raw, fire_nxt;
    logic [3:0] dir_q;
    logic [2:0] code_q;
    logic       valid_q, fire_q, start_q;

    assign fire_raw     = joy_sync[7*p+4];
    assign coin_sync[p] = joy_sync[7*p+6];

    always_comb begin
      rgt   = joy_sync[7*p+0] & ~joy_sync[7*p+1];
      lft   = joy_sync[7*p+1] & ~joy_sync[7*p+0];
      dwn   = joy_sync[7*p+2] & ~joy_sync[7*p+3];
      up    = joy_sync[7*p+3] & ~joy_sync[7*p+2];
      vert  = up | dwn;
      horz  = rgt | lft;
      clean = {up, dwn, lft, rgt};
      // 4-way diagonal: keep the axis that was last pressed on its own
      if (!mode_8way[p] && vert && horz) begin
        if (last_horz) clean[3:2] = 2'b00;
        else           clean[1:0] = 2'b00;
      end
      case (clean)
        4'b1000: code = 3'd0;
        4'b1001: code = 3'd1;
        4'b0001: code = 3'd2;
        4'b0101: code = 3'd3;
        4'b0100: code = 3'd4;
        4'b0110: code = 3'd5;
        4'b0010: code = 3'd6;
        4'b1010: code = 3'd7;
        default: code = 3'd0;
      endcase
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    localparam logic [7:0] AF_LAST = 8'(AUTOFIRE_RATE - 1);

    logic       fire_last, af_low, af_low_nxt;
    logic [7:0] af_cnt, af_cnt_nxt;

    always_comb begin
      af_low_nxt = 1'b0;
      af_cnt_nxt = 8'd0;
      // Phase restarts high on every fresh press
      if (fire_raw && fire_last) begin
        af_low_nxt = af_low;
        af_cnt_nxt = af_cnt;
        if (frame_tick) begin
          if (af_cnt == AF_LAST) begin
            af_cnt_nxt = 8'd0;
            af_low_nxt = ~af_low;
          end else begin
            af_cnt_nxt = af_cnt + 8'd1;
          end
        end
      end
      fire_nxt = fire_raw & ~(autofire_en[p] & af_low_nxt);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        fire_last <= 1'b0;
        af_low    <= 1'b0;
        af_cnt    <= 8'd0;
      end else begin
        fire_last <= fire_raw;
        af_low    <= af_low_nxt;
        af_cnt    <= af_cnt_nxt;
      end
    end
`else
    assign fire_nxt = fire_raw;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        last_horz <= 1'b0;
        dir_q     <= 4'd0;
        code_q    <= 3'd0;
        valid_q   <= 1'b0;
        fire_q    <= 1'b0;
        start_q   <= 1'b0;
      end else begin
        if (vert ^ horz) last_horz <= horz;
        dir_q   <= clean;
        code_q  <= code;
        valid_q <= |clean;
        fire_q  <= fire_nxt;
        start_q <= joy_sync[7*p+5];
      end
    end

    assign dir_out[4*p +: 4]  = dir_q;
    assign dir_code[3*p +: 3] = code_q;
    assign dir_valid[p]       = valid_q;
    assign fire_out[p]        = fire_q;
    assign start_out[p]       = start_q;
  end

  logic [NPLAYERS-1:0] coin_last, coin_rise, pending, pend_clr;
  logic [1:0]          state, state_nxt;
  logic [7:0]          frame_cnt, frame_cnt_nxt;
  logic                accept, coin_out_nxt;

  assign coin_rise = coin_sync & ~coin_last;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      frame_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      frame_cnt <= frame_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    case (state)
      ST_IDLE: begin
        if (|pending) begin
          state_nxt     = ST_PULSE;
          frame_cnt_nxt = 8'd0;
        end
      end
      ST_PULSE: begin
        if (frame_tick) begin
          if (frame_cnt == PULSE_LAST) begin
            state_nxt     = ST_GAP;
            frame_cnt_nxt = 8'd0;
          end else begin
            frame_cnt_nxt = frame_cnt + 8'd1;
          end
        end
      end
      ST_GAP: begin
        if (frame_tick) begin
          if (frame_cnt == GAP_LAST) begin
            state_nxt     = ST_IDLE;
            frame_cnt_nxt = 8'd0;
          end else begin
            frame_cnt_nxt = frame_cnt + 8'd1;
          end
        end
      end
      default: begin
        state_nxt     = ST_IDLE;
        frame_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Lowest set pending bit is isolated with x & -x
  always_comb begin
    accept       = (state == ST_IDLE) && (|pending);
    pend_clr     = accept ? (pending & (~pending + NPLAYERS'(1))) : '0;
    coin_out_nxt = (state_nxt == ST_PULSE);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      coin_last  <= '0;
      pending    <= '0;
      coin_out   <= 1'b0;
      coin_count <= 8'd0;
    end else begin
      coin_last <= coin_sync;
      pending   <= (pending & ~pend_clr) | coin_rise;
      coin_out  <= coin_out_nxt;
      if (accept) coin_count <= coin_count + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arcade_input_mapper.sv
`default_nettype none
// ============================================================================
// Module  : tb_arcade_input_mapper
// Purpose : Self-checking bench for arcade_input_mapper (table, random, coin,
//           reset and optional autofire sequences).
// Rev     : 1.0  initial release
// ============================================================================
module tb_arcade_input_mapper;

  localparam int NP = 2;

  logic            clk_sys = 1'b0;
  logic            reset;
  logic            vblank;
  logic [7*NP-1:0] joy_in;
  logic [NP-1:0]   mode_8way;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  logic [NP-1:0]   autofire_en;
`endif
  logic [4*NP-1:0] dir_out;
  logic [3*NP-1:0] dir_code;
  logic [NP-1:0]   dir_valid, fire_out, start_out;
  logic            coin_out;
  logic [7:0]      coin_count;

  int vectors = 0;
  int miscompares = 0;
  int exp_count = 0;

  arcade_input_mapper #(
    .NPLAYERS(NP), .COIN_PULSE(4), .COIN_GAP(2), .AUTOFIRE_RATE(3)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .vblank(vblank), .joy_in(joy_in),
    .mode_8way(mode_8way),
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    .autofire_en(autofire_en),
`endif
    .dir_out(dir_out), .dir_code(dir_code), .dir_valid(dir_valid),
    .fire_out(fire_out), .start_out(start_out), .coin_out(coin_out),
    .coin_count(coin_count)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic frame();
    vblank = 1'b1;
    step(4);
    vblank = 1'b0;
    step(4);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  // Reference: signed axes, opposite pairs cancel, code from a 3x3 compass grid
  function automatic void model(input logic [6:0] raw, input logic m8, inout logic lh,
                                output logic [3:0] d, output logic [2:0] c, output logic v);
    int dx, dy, ax, ay;
    int compass [9] = '{5, 4, 3, 6, 0, 2, 7, 0, 1};
    ax = int'(raw[0]) - int'(raw[1]);
    ay = int'(raw[3]) - int'(raw[2]);
    dx = ax;
    dy = ay;
    if (!m8 && dx != 0 && dy != 0) begin
      if (lh) dy = 0;
      else    dx = 0;
    end
    if ((ax != 0) != (ay != 0)) lh = (ax != 0);
    d = {dy > 0, dy < 0, dx < 0, dx > 0};
    c = 3'(compass[(dy + 1) * 3 + (dx + 1)]);
    v = (dx != 0) || (dy != 0);
  endfunction

  task automatic single_coin();
    joy_in[6] = 1'b1;
    step(6);
    chk("coin_single_high", 32'(coin_out), 32'd1);
    exp_count = (exp_count + 1) % 256;
    joy_in[6] = 1'b0;
    repeat (6) frame();
    chk("coin_single_count", 32'(coin_count), 32'(exp_count));
  endtask

  typedef struct {
    logic [3:0] dirs;
    logic [3:0] exp_dir;
    logic [2:0] exp_code;
    logic       exp_valid;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic       lh [NP];
    logic [6:0] raw [NP];
    logic [3:0] ed;
    logic [2:0] ec;
    logic       ev;

    tbl[0]  = '{4'b1001, 4'b1001, 3'd1, 1'b1};
    tbl[1]  = '{4'b0001, 4'b0001, 3'd2, 1'b1};
    tbl[2]  = '{4'b0101, 4'b0101, 3'd3, 1'b1};
    tbl[3]  = '{4'b0100, 4'b0100, 3'd4, 1'b1};
    tbl[4]  = '{4'b0110, 4'b0110, 3'd5, 1'b1};
    tbl[5]  = '{4'b0010, 4'b0010, 3'd6, 1'b1};
    tbl[6]  = '{4'b1010, 4'b1010, 3'd7, 1'b1};
    tbl[7]  = '{4'b1000, 4'b1000, 3'd0, 1'b1};
    tbl[8]  = '{4'b1110, 4'b0010, 3'd6, 1'b1};
    tbl[9]  = '{4'b1111, 4'b0000, 3'd0, 1'b0};
    tbl[10] = '{4'b0011, 4'b0000, 3'd0, 1'b0};
    tbl[11] = '{4'b1100, 4'b0000, 3'd0, 1'b0};

    reset     = 1'b1;
    vblank    = 1'b0;
    joy_in    = '0;
    mode_8way = '0;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    autofire_en = '0;
`endif
    step(2);
    chk("reset_dir_out", 32'(dir_out), 32'd0);
    chk("reset_dir_code", 32'(dir_code), 32'd0);
    chk("reset_dir_valid", 32'(dir_valid), 32'd0);
    chk("reset_fire", 32'(fire_out), 32'd0);
    chk("reset_start", 32'(start_out), 32'd0);
    chk("reset_coin_out", 32'(coin_out), 32'd0);
    chk("reset_coin_count", 32'(coin_count), 32'd0);
    reset = 1'b0;
    step(1);

    // 4-way diagonal with no history: vertical wins
    joy_in[6:0] = 7'b0001001;
    step(3);
    chk("nohist_dir", 32'(dir_out[3:0]), 32'b1000);
    chk("nohist_code", 32'(dir_code[2:0]), 32'd0);

    // 8-way table with exact 3-cycle latency
    mode_8way = 2'b11;
    joy_in = '0;
    step(4);
    for (int i = 0; i < 12; i++) begin
      joy_in[3:0] = tbl[i].dirs;
      step(3);
      chk($sformatf("tbl%0d_dir", i), 32'(dir_out[3:0]), 32'(tbl[i].exp_dir));
      chk($sformatf("tbl%0d_code", i), 32'(dir_code[2:0]), 32'(tbl[i].exp_code));
      chk($sformatf("tbl%0d_valid", i), 32'(dir_valid[0]), 32'(tbl[i].exp_valid));
    end

    // 4-way history: first axis pressed alone holds through the diagonal
    mode_8way = 2'b00;
    joy_in[3:0] = 4'b1000; step(4);
    joy_in[3:0] = 4'b1001; step(4);
    chk("4way_u_then_ur", 32'(dir_out[3:0]), 32'b1000);
    joy_in[3:0] = 4'b0001; step(4);
    joy_in[3:0] = 4'b1001; step(4);
    chk("4way_r_then_ru", 32'(dir_out[3:0]), 32'b0001);
    chk("4way_r_then_ru_code", 32'(dir_code[2:0]), 32'd2);

    // Randomised directions, fire and start against the reference model
    joy_in = '0;
    do_reset();
    for (int p = 0; p < NP; p++) lh[p] = 1'b0;
    for (int it = 0; it < 200; it++) begin
      for (int p = 0; p < NP; p++) begin
        raw[p] = 7'($urandom_range(0, 63));
        mode_8way[p] = 1'($urandom_range(0, 1));
        joy_in[7*p +: 7] = raw[p];
      end
      step(4);
      for (int p = 0; p < NP; p++) begin
        model(raw[p], mode_8way[p], lh[p], ed, ec, ev);
        chk($sformatf("rnd%0d_p%0d_dir", it, p), 32'(dir_out[4*p +: 4]), 32'(ed));
        chk($sformatf("rnd%0d_p%0d_code", it, p), 32'(dir_code[3*p +: 3]), 32'(ec));
        chk($sformatf("rnd%0d_p%0d_valid", it, p), 32'(dir_valid[p]), 32'(ev));
        chk($sformatf("rnd%0d_p%0d_fire", it, p), 32'(fire_out[p]), 32'(raw[p][4]));
        chk($sformatf("rnd%0d_p%0d_start", it, p), 32'(start_out[p]), 32'(raw[p][5]));
      end
    end

    // Simultaneous coins from both players: two separate pulses
    joy_in = '0;
    do_reset();
    exp_count = 0;
    joy_in[6]  = 1'b1;
    joy_in[13] = 1'b1;
    step(6);
    chk("dual_first_high", 32'(coin_out), 32'd1);
    chk("dual_first_count", 32'(coin_count), 32'd1);
    joy_in = '0;
    for (int f = 1; f <= 3; f++) begin
      frame();
      chk($sformatf("dual_p1_frame%0d", f), 32'(coin_out), 32'd1);
    end
    frame();
    chk("dual_p1_end", 32'(coin_out), 32'd0);
    frame();
    chk("dual_gap1", 32'(coin_out), 32'd0);
    frame();
    chk("dual_second_high", 32'(coin_out), 32'd1);
    chk("dual_second_count", 32'(coin_count), 32'd2);
    for (int f = 1; f <= 3; f++) begin
      frame();
      chk($sformatf("dual_p2_frame%0d", f), 32'(coin_out), 32'd1);
    end
    frame();
    chk("dual_p2_end", 32'(coin_out), 32'd0);
    repeat (3) frame();
    chk("dual_no_third", 32'(coin_out), 32'd0);
    chk("dual_final_count", 32'(coin_count), 32'd2);
    exp_count = 2;

    // Count up to 255 then wrap
    while (exp_count != 255) single_coin();
    chk("count_at_255", 32'(coin_count), 32'd255);
    single_coin();
    chk("count_wrap", 32'(coin_count), 32'd0);

    // Reset in the middle of a pulse
    joy_in[6] = 1'b1;
    step(6);
    chk("midrst_high", 32'(coin_out), 32'd1);
    joy_in[6] = 1'b0;
    frame();
    chk("midrst_still_high", 32'(coin_out), 32'd1);
    @(posedge clk_sys);
    #3 reset = 1'b1;
    #1;
    chk("midrst_coin_low", 32'(coin_out), 32'd0);
    chk("midrst_count", 32'(coin_count), 32'd0);
    step(2);
    reset = 1'b0;
    for (int f = 0; f < 8; f++) begin
      frame();
      chk($sformatf("midrst_no_replay%0d", f), 32'(coin_out), 32'd0);
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    do_reset();
    autofire_en = 2'b01;
    mode_8way   = 2'b00;
    joy_in[4]   = 1'b1;
    step(3);
    for (int f = 0; f < 12; f++) begin
      chk($sformatf("autofire_frame%0d", f), 32'(fire_out[0]), 32'(((f / 3) % 2) == 0));
      frame();
    end
    joy_in[4] = 1'b0;
    step(3);
    chk("autofire_release", 32'(fire_out[0]), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
